// File: rtl/dsp_decimator.sv
// ---------------------------------------------------------------------------
// dsp_decimator
//
// Purpose:
//   Decimates a stream of FIR output samples by DECIM and queues each result
//   in a small output FIFO with a valid/ready read side. The input side has
//   no backpressure. When the FIFO is full and nothing is read on the same
//   edge, a new result is dropped and a sticky overflow flag is set.
//
// Build option:
//   DSP_DECIM_AVG_EN  defined     -> the result is the truncated mean of the
//                                    DECIM samples in a group.
//                     not defined -> the result is the last sample of each
//                                    group. No accumulator is built.
//
// Parameters:
//   DATA_WIDTH  sample width (unsigned)
//   DECIM       decimation ratio (power of two, >= 2)
//   FIFO_DEPTH  output FIFO entries (power of two, >= 2)
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous active-high reset
//   in_valid    in_data carries a sample this cycle
//   in_data     input sample
//   out_valid   out_data holds the FIFO head
//   out_ready   consumer takes the head when out_valid is also high
//   out_data    FIFO head (zero while the FIFO is empty)
//   fifo_level  current FIFO occupancy
//   overflow    sticky: a decimated result was dropped (cleared by rst only)
// ---------------------------------------------------------------------------
module dsp_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PHASE_W = $clog2(DECIM);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;

  // -------------------------------------------------------------------------
  // Phase counter: counts accepted samples only, wraps at DECIM-1.
  // -------------------------------------------------------------------------
  logic [PHASE_W-1:0] phase;
  logic               phase_last;
  logic               group_done;

  assign phase_last = (phase == PHASE_W'(DECIM - 1));
  assign group_done = in_valid && phase_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= phase_last ? '0 : phase + PHASE_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Result computation.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] result;

`ifdef DSP_DECIM_AVG_EN
  localparam int ACC_W = DATA_WIDTH + PHASE_W;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // acc_sum includes the current sample, so on the last sample of a group it
  // is already the full group sum; the accumulator wide enough never wraps.
  assign acc_sum = acc + ACC_W'(in_data);
  // Dividing by a power of two is just dropping the low bits (truncation).
  assign result  = acc_sum[ACC_W-1:PHASE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= group_done ? '0 : acc_sum;
    end
  end
`else
  assign result = in_data;
`endif

  // -------------------------------------------------------------------------
  // Output FIFO.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A same-edge pop frees a slot, so a full FIFO can still accept the push.
  assign push      = group_done && (!full || pop);
  assign drop      = group_done && full && !pop;

  // Storage has no reset: out_data is forced to zero while empty, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= result;
    end
  end

  // Pointers are PTR_W bits wide and FIFO_DEPTH is a power of two, so the
  // natural binary wrap is the modulo-FIFO_DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_dsp_decimator.sv
// ---------------------------------------------------------------------------
// tb_dsp_decimator
//
// Scoreboard bench for dsp_decimator (DATA_WIDTH=16, DECIM=4, FIFO_DEPTH=4).
// The stimulus side keeps the samples of the current group. When a group
// completes, it computes the expected result with plain arithmetic and
// appends it to a queue that models the FIFO contents. A monitor runs on
// the falling edge. It compares out_valid, fifo_level, overflow and out_data
// with the queue, then pops the queue whenever the DUT is being read on the
// coming edge. Each comparison prints one line.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dsp_decimator;

  localparam int DW = 16;
  localparam int DECIM = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [$clog2(FD):0] fifo_level;
  logic          overflow;

  always #5 clk = ~clk;

  dsp_decimator #(.DATA_WIDTH(DW), .DECIM(DECIM), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  // Reference model state.
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q[$];   // expected FIFO contents, head first
  int            grp[$];     // samples of the group in progress
  bit            model_ovf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  // Expected decimated value of a complete group.
  function automatic logic [DW-1:0] group_result();
    int sum;
    sum = 0;
    foreach (grp[i]) sum += grp[i];
`ifdef DSP_DECIM_AVG_EN
    return DW'(sum / DECIM);
`else
    return DW'(grp[DECIM-1]);
`endif
  endfunction

  // Monitor: compare the visible state with the model, then account for the
  // pop that happens on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("fifo_level", int'(fifo_level), exp_q.size());
      check("overflow", int'(overflow), int'(model_ovf));
      if (exp_q.size() > 0) begin
        check("out_data", int'(out_data), int'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus. It is entered and left at posedge+1.
  // The model runs just after the monitor, so exp_q already reflects this
  // edge's pop. The push succeeds exactly when a slot is then free.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    #1;
    if (v) begin
      grp.push_back(int'(d));
      if (grp.size() == DECIM) begin
        if (exp_q.size() < FD) exp_q.push_back(group_result());
        else model_ovf = 1'b1;
        grp.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted mid-cycle. The outputs are checked before any clock
  // edge, then reset is held across one edge and released mid-cycle.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst fifo_level", int'(fifo_level), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst out_data", int'(out_data), 0);
    exp_q.delete();
    grp.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #3;
    check("init out_valid", int'(out_valid), 0);
    check("init fifo_level", int'(fifo_level), 0);
    check("init overflow", int'(overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Four back-to-back samples, then idle cycles with no further output.
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b1);
    check("b2b out_valid", int'(out_valid), 1);
`ifdef DSP_DECIM_AVG_EN
    check("b2b out_data", int'(out_data), 2);
`else
    check("b2b out_data", int'(out_data), 4);
`endif
    repeat (4) cycle(1'b0, '0, 1'b1);

    // The same samples separated by 3 idle cycles each.
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, DW'(i), 1'b1);
      if (i < 4) repeat (3) cycle(1'b0, 16'hdead, 1'b1);
    end
    check("gap out_valid", int'(out_valid), 1);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // Overflow: 20 samples with the consumer stalled, then drain.
    for (int i = 1; i <= 20; i++) cycle(1'b1, DW'(i), 1'b0);
    check("ovf fifo_level", int'(fifo_level), 4);
    check("ovf overflow", int'(overflow), 1);
`ifdef DSP_DECIM_AVG_EN
    check("ovf head", int'(out_data), 2);
`else
    check("ovf head", int'(out_data), 4);
`endif
    repeat (3) cycle(1'b0, '0, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1);
    check("drain fifo_level", int'(fifo_level), 0);
    check("drain overflow", int'(overflow), 1);

    // Reset clears overflow. Then fill the FIFO and complete a group on the
    // same edge as a pop.
    do_reset();
    for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0);
    for (int i = 17; i <= 19; i++) cycle(1'b1, DW'(i), 1'b0);
    cycle(1'b1, DW'(20), 1'b1);
    check("full push+pop level", int'(fifo_level), 4);
    check("full push+pop overflow", int'(overflow), 0);
    // Reset while the FIFO is occupied.
    do_reset();

    // Partial group discarded by reset.
    cycle(1'b1, DW'(9), 1'b1);
    cycle(1'b1, DW'(9), 1'b1);
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1);
`ifdef DSP_DECIM_AVG_EN
    check("post-rst out_data", int'(out_data), 6);
`else
    check("post-rst out_data", int'(out_data), 8);
`endif
    check("post-rst overflow", int'(overflow), 0);
    repeat (4) cycle(1'b0, '0, 1'b1);

    // Random traffic with stall bursts and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      logic v, r;
      v = ($urandom_range(0, 3) != 0);
      r = ((n / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      cycle(v, DW'($urandom), r);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    repeat (8) cycle(1'b0, '0, 1'b1);
    check("final fifo_level", int'(fifo_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
